// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the fetch PC, issues word requests on a pipelined instruction bus
// (req/gnt address phase, in-order rvalid data phase) and buffers returned
// words in a 2-entry prefetch FIFO whose head drives pc_o/inst_o.
// A branch redirect from EX flushes the FIFO and discards every response
// that is still on its way back.
//
// Handshakes:
//   address phase : a request is accepted in any cycle where ibus_req_o and
//                   ibus_gnt_i are both 1; ibus_addr_o is only allowed to
//                   change after such a cycle or on a redirect.
//   data phase    : ibus_rvalid_i marks one response word, returned in
//                   request order, at the earliest one cycle after its grant.
//   IF/ID         : the head entry is consumed in a cycle where stalled[1]
//                   is 0, the FIFO is non-empty and no redirect is present.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous reset, active low
//   ex_branch_flag_i  redirect from EX this cycle
//   ex_branch_addr_i  redirect target (word aligned)
//   stalled[5:0]      pipeline stall vector; only stalled[1] is used here
//   ibus_req_o        address-phase request
//   ibus_addr_o       request address (= fetch PC)
//   ibus_gnt_i        request accepted
//   ibus_rvalid_i     response valid
//   ibus_rdata_i      response word
//   pc_o / inst_o     FIFO head, or zero (bubble) when the FIFO is empty
// ----------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_branch_flag_i,
   input  logic [31:0] ex_branch_addr_i,
   input  logic [5:0]  stalled,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // fetch state
   logic [31:0] r_fetch_pc;
   logic [1:0]  r_outstanding;   // requests granted but not yet answered
   logic [1:0]  r_drop_cnt;      // of those, how many belong to a flushed path

   // prefetch FIFO
   logic [31:0] r_fifo_pc   [0:1];
   logic [31:0] r_fifo_inst [0:1];
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_count;

   // pcs of live (non-dropped) in-flight requests, in request order
   logic [31:0] r_ifq_pc [0:1];
   logic        r_ifq_rd;
   logic        r_ifq_wr;

   logic        w_pop;
   logic        w_push;
   logic        w_grant;
   logic [2:0]  w_occupancy;
   logic        w_room;
   logic        w_unused_in;

   assign w_pop = !stalled[1] && (r_count != 2'd0) && !ex_branch_flag_i;

   // Slots already spoken for: buffered words plus words still in flight,
   // less the one IF/ID takes this cycle. A new request is only made when a
   // FIFO slot is guaranteed for its response, so the FIFO can never overflow.
   assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding} - {2'b00, w_pop};
   assign w_room      = (w_occupancy < 3'd2);

   // Gated with rst so the request is low while reset is held and rises as
   // soon as it is released.
   assign ibus_req_o  = rst && !ex_branch_flag_i && w_room;
   assign ibus_addr_o = r_fetch_pc;
   assign w_grant     = ibus_req_o && ibus_gnt_i;

   // Words from a flushed path are counted off by r_drop_cnt; the branch cycle
   // itself discards any word arriving with it.
   assign w_push = ibus_rvalid_i && (r_drop_cnt == 2'd0) && !ex_branch_flag_i;

   assign pc_o   = (r_count == 2'd0) ? ZERO_WORD : r_fifo_pc[r_rd_ptr];
   assign inst_o = (r_count == 2'd0) ? ZERO_WORD : r_fifo_inst[r_rd_ptr];

   assign w_unused_in = ^{stalled[5:2], stalled[0], ex_branch_addr_i[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc     <= RESET_PC;
         r_outstanding  <= 2'd0;
         r_drop_cnt     <= 2'd0;
         r_fifo_pc[0]   <= ZERO_WORD;
         r_fifo_pc[1]   <= ZERO_WORD;
         r_fifo_inst[0] <= ZERO_WORD;
         r_fifo_inst[1] <= ZERO_WORD;
         r_rd_ptr       <= 1'b0;
         r_wr_ptr       <= 1'b0;
         r_count        <= 2'd0;
         r_ifq_pc[0]    <= ZERO_WORD;
         r_ifq_pc[1]    <= ZERO_WORD;
         r_ifq_rd       <= 1'b0;
         r_ifq_wr       <= 1'b0;
      end else if (ex_branch_flag_i) begin
         // Redirect: everything still to come back belongs to the old path.
         r_fetch_pc    <= {ex_branch_addr_i[31:2], 2'b00};
         r_outstanding <= r_outstanding - {1'b0, ibus_rvalid_i};
         r_drop_cnt    <= r_outstanding - {1'b0, ibus_rvalid_i};
         r_rd_ptr      <= 1'b0;
         r_wr_ptr      <= 1'b0;
         r_count       <= 2'd0;
         r_ifq_rd      <= 1'b0;
         r_ifq_wr      <= 1'b0;
      end else begin
         if (w_grant) begin
            r_fetch_pc         <= r_fetch_pc + 32'd4;
            r_ifq_pc[r_ifq_wr] <= r_fetch_pc;
            r_ifq_wr           <= !r_ifq_wr;
         end
         r_outstanding <= r_outstanding + {1'b0, w_grant} - {1'b0, ibus_rvalid_i};
         if (ibus_rvalid_i && (r_drop_cnt != 2'd0)) begin
            r_drop_cnt <= r_drop_cnt - 2'd1;
         end
         if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_ifq_pc[r_ifq_rd];
            r_fifo_inst[r_wr_ptr] <= ibus_rdata_i;
            r_wr_ptr              <= !r_wr_ptr;
            r_ifq_rd              <= !r_ifq_rd;
         end
         if (w_pop) begin
            r_rd_ptr <= !r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(w_push && (r_count == 2'd2) && !w_pop));

   a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst)
      !(ibus_rvalid_i && (r_outstanding == 2'd0)));

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br;
  logic [31:0] br_addr;
  logic [5:0]  stalled;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  wire         req;
  wire  [31:0] addr;
  wire  [31:0] pc;
  wire  [31:0] inst;
  wire         req2;
  wire  [31:0] addr2;
  wire  [31:0] pc2;
  wire  [31:0] inst2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .ex_branch_flag_i(br), .ex_branch_addr_i(br_addr),
    .stalled(stalled),
    .ibus_req_o(req), .ibus_addr_o(addr),
    .ibus_gnt_i(gnt), .ibus_rvalid_i(rvalid), .ibus_rdata_i(rdata),
    .pc_o(pc), .inst_o(inst)
  );

  // second instance only to exercise the fetch-PC wrap from the top word
  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst),
    .ex_branch_flag_i(1'b0), .ex_branch_addr_i(32'h0),
    .stalled(6'h00),
    .ibus_req_o(req2), .ibus_addr_o(addr2),
    .ibus_gnt_i(1'b1), .ibus_rvalid_i(1'b0), .ibus_rdata_i(32'h0),
    .pc_o(pc2), .inst_o(inst2)
  );

  // ---------------- model state ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; bit drop; } inf_t;
  typedef struct { int due; logic [31:0] addr; } bus_t;

  ent_t        m_fifo[$];
  inf_t        m_inf[$];
  logic [31:0] m_fetch_pc;
  bus_t        bus_q[$];
  int          last_due;
  int          lat_lo;
  int          lat_hi;
  int          cyc;

  int          n_checks = 0;
  int          n_err = 0;

  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic        s2_req;
  logic [31:0] s2_addr;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply_reset();
    br = 1'b0; br_addr = 32'h0; stalled = 6'h00; gnt = 1'b0;
    rvalid = 1'b0; rdata = 32'h0;
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_addr2", addr2, 32'hFFFF_FFFC);
    m_fifo.delete();
    m_inf.delete();
    bus_q.delete();
    m_fetch_pc = 32'h0;
    last_due = -1;
    cyc = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One bus cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input bit g, input logic [5:0] st, input bit b, input logic [31:0] ba);
    bit          rv;
    bit          pop_m;
    bit          req_m;
    logic [31:0] rd;
    logic [31:0] epc;
    logic [31:0] einst;
    inf_t        f;
    ent_t        e;
    bus_t        t;
    rv = (bus_q.size() != 0) && (bus_q[0].due <= cyc);
    rd = rv ? (bus_q[0].addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    gnt = g; stalled = st; br = b; br_addr = ba; rvalid = rv; rdata = rd;
    #2;
    pop_m = !st[1] && (m_fifo.size() != 0) && !b;
    req_m = !b && ((m_fifo.size() + m_inf.size() - int'(pop_m)) < 2);
    epc   = (m_fifo.size() != 0) ? m_fifo[0].pc : 32'h0;
    einst = (m_fifo.size() != 0) ? m_fifo[0].inst : 32'h0;
    s_req = req; s_addr = addr; s_pc = pc; s_inst = inst;
    s2_req = req2; s2_addr = addr2;
    chk("req", 32'(req), 32'(req_m));
    chk("addr", addr, m_fetch_pc);
    chk("pc", pc, epc);
    chk("inst", inst, einst);
    // model update for the coming edge
    if (rv) void'(bus_q.pop_front());
    if (b) begin
      m_fifo.delete();
      if (rv) void'(m_inf.pop_front());
      foreach (m_inf[i]) m_inf[i].drop = 1'b1;
      m_fetch_pc = ba;
    end else begin
      if (pop_m) void'(m_fifo.pop_front());
      if (rv) begin
        f = m_inf.pop_front();
        if (!f.drop) begin
          e.pc = f.pc; e.inst = rd;
          m_fifo.push_back(e);
        end
      end
      if (req_m && g) begin
        f.pc = m_fetch_pc; f.drop = 1'b0;
        m_inf.push_back(f);
        t.addr = m_fetch_pc;
        t.due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (t.due <= last_due) t.due = last_due + 1;
        last_due = t.due;
        bus_q.push_back(t);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #3;
    // A: zero-wait bus, no stalls; wrap check on the second instance
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 6'h00, 1'b0, 32'h0);
      case (c)
        0: begin
          chk("a_c0_req", 32'(s_req), 32'h1);
          chk("a_c0_addr", s_addr, 32'h0);
          chk("w_c0_req2", 32'(s2_req), 32'h1);
          chk("w_c0_addr2", s2_addr, 32'hFFFF_FFFC);
        end
        1: begin
          chk("a_c1_addr", s_addr, 32'h4);
          chk("w_c1_addr2", s2_addr, 32'h0);
        end
        2: begin
          chk("a_c2_pc", s_pc, 32'h0);
          chk("a_c2_inst", s_inst, 32'hA5A5_0000);
          chk("w_c2_req2", 32'(s2_req), 32'h0);
        end
        3: begin
          chk("a_c3_pc", s_pc, 32'h4);
          chk("a_c3_inst", s_inst, 32'hA5A5_0004);
        end
        4: chk("a_c4_pc", s_pc, 32'h8);
        default: ;
      endcase
    end

    // B: IF/ID stalled for 5 cycles (reset also clears a busy FIFO at once)
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, (c < 5) ? 6'h02 : 6'h00, 1'b0, 32'h0);
      case (c)
        2: chk("b_c2_req", 32'(s_req), 32'h0);
        4: begin
          chk("b_c4_req", 32'(s_req), 32'h0);
          chk("b_c4_pc", s_pc, 32'h0);
        end
        5: chk("b_c5_pc", s_pc, 32'h0);
        6: chk("b_c6_pc", s_pc, 32'h4);
        7: chk("b_c7_pc", s_pc, 32'h8);
        default: ;
      endcase
    end

    // C: branch to 0x100 with two requests outstanding, 3-cycle latency
    lat_lo = 3; lat_hi = 3;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 6'h00, (c == 2), 32'h100);
      case (c)
        3: begin
          chk("c_c3_pc", s_pc, 32'h0);
          chk("c_c3_inst", s_inst, 32'h0);
        end
        4: begin
          chk("c_c4_req", 32'(s_req), 32'h1);
          chk("c_c4_addr", s_addr, 32'h100);
        end
        7: chk("c_c7_pc", s_pc, 32'h0);
        8: begin
          chk("c_c8_pc", s_pc, 32'h100);
          chk("c_c8_inst", s_inst, 32'hA5A5_0100);
        end
        default: ;
      endcase
    end

    // D: branch together with an arriving word that would fill the FIFO
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, (c < 3) ? 6'h02 : 6'h00, (c == 2), 32'h200);
      case (c)
        3: begin
          chk("d_c3_pc", s_pc, 32'h0);
          chk("d_c3_inst", s_inst, 32'h0);
          chk("d_c3_req", 32'(s_req), 32'h1);
          chk("d_c3_addr", s_addr, 32'h200);
        end
        5: begin
          chk("d_c5_pc", s_pc, 32'h200);
          chk("d_c5_inst", s_inst, 32'hA5A5_0200);
        end
        default: ;
      endcase
    end

    // E: grant withheld for 4 cycles; stalled[0] set throughout
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      cycle((c >= 4), 6'h01, 1'b0, 32'h0);
      case (c)
        3: begin
          chk("e_c3_req", 32'(s_req), 32'h1);
          chk("e_c3_addr", s_addr, 32'h0);
          chk("e_c3_inst", s_inst, 32'h0);
        end
        6: begin
          chk("e_c6_pc", s_pc, 32'h0);
          chk("e_c6_inst", s_inst, 32'hA5A5_0000);
        end
        default: ;
      endcase
    end

    // F: mixed traffic, variable latency, occasional redirects
    lat_lo = 1; lat_hi = 3;
    apply_reset();
    for (int c = 0; c < 150; c++) begin
      logic [5:0] st;
      st = 6'h00;
      st[1] = ($urandom_range(0, 3) == 0);
      cycle(($urandom_range(0, 3) != 0), st, ($urandom_range(0, 14) == 0),
            32'h1000 + (32'($urandom_range(0, 63)) << 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
